// File: rtl/grey_edge_pkg.sv
// Shared constants for the grey/Sobel edge pipeline.
package grey_edge_pkg;

    // RGB444 field offsets inside a 12-bit pixel
    localparam int R_LSB = 8;
    localparam int G_LSB = 4;
    localparam int B_LSB = 0;

    // Grey sample and edge magnitude width
    localparam int PIX_W = 4;

    // Sobel magnitude is scaled down by this shift before saturation
    localparam int MAG_SHIFT = 3;

    // Largest representable edge value
    localparam int EDGE_MAX = 15;

endpackage

// File: rtl/rgb444_to_grey4.sv
// Registered RGB444 -> 4-bit grey converter: grey = (R + 2G + B) >> 2.
module rgb444_to_grey4
    import grey_edge_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [11:0]      pixel_in,
    input  logic             pix_vld,
    output logic [PIX_W-1:0] grey_p0,
    output logic             vld_p0
);

    logic [5:0] sum;

    // 6-bit sum holds the worst case 15 + 30 + 15 = 60
    always_comb begin
        sum = {2'b00, pixel_in[R_LSB +: PIX_W]}
            + {1'b0, pixel_in[G_LSB +: PIX_W], 1'b0}
            + {2'b00, pixel_in[B_LSB +: PIX_W]};
    end

    // Stage p0: valid is control and is cleared by reset; a strobe during reset is dropped
    always_ff @(posedge clk) begin
        if (rst) vld_p0 <= 1'b0;
        else     vld_p0 <= pix_vld;
    end

    // Stage p0: grey data register, free-running
    always_ff @(posedge clk) begin
        grey_p0 <= sum[5:2];
    end

endmodule

// File: rtl/grey_edge_pipeline.sv
// RGB444 stream -> grey -> 3x3 Sobel magnitude, one output per accepted pixel,
// delayed by IMG_W+1 accepted pixels.
module grey_edge_pipeline
    import grey_edge_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] pixel_in,
    input  logic        in_ready,
    output logic [3:0]  edge_data,
    output logic        out_ready
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W + 2);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [CW-1:0] PRIME  = CW'(IMG_W + 1);
    localparam logic [7:0]    MAX8   = 8'(EDGE_MAX);

    logic [PIX_W-1:0] grey_p0;
    logic             vld_p0;

    // Line buffers: lb0 holds the previous row, lb1 the row before that
    logic [PIX_W-1:0] lb0 [IMG_W];
    logic [PIX_W-1:0] lb1 [IMG_W];
    // 3x3 window, win[row][col], row 0 is the top (oldest) row
    logic [PIX_W-1:0] win [3][3];

    logic [XW-1:0] cx;        // column being written into the line buffers
    logic [CW-1:0] cnt;       // accepted pixels since reset, saturates at IMG_W+1
    logic [XW-1:0] ox;        // coordinates of the next pixel to be emitted
    logic [YW-1:0] oy;
    logic          vld_p1;
    logic          bdr_p1;

    logic signed [7:0] gx;
    logic signed [7:0] gy;
    logic [7:0]        mag;

    function automatic logic signed [7:0] ext(input logic [PIX_W-1:0] p);
        return {4'b0000, p};
    endfunction

    function automatic logic [7:0] abs8(input logic signed [7:0] v);
        return (v < 0) ? 8'(-v) : 8'(v);
    endfunction

    function automatic logic [PIX_W-1:0] sat_edge(input logic [7:0] m);
        logic [7:0] s;
        s = m >> MAG_SHIFT;
        return (s > MAX8) ? MAX8[PIX_W-1:0] : s[PIX_W-1:0];
    endfunction

    rgb444_to_grey4 u_grey (
        .clk      (clk),
        .rst      (rst),
        .pixel_in (pixel_in),
        .pix_vld  (in_ready),
        .grey_p0  (grey_p0),
        .vld_p0   (vld_p0)
    );

    // Stage p1 control: counters, priming, and border flag of the emitted pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            cx     <= '0;
            cnt    <= '0;
            ox     <= '0;
            oy     <= '0;
            vld_p1 <= 1'b0;
            bdr_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 && (cnt == PRIME);
            if (vld_p0) begin
                cx <= (cx == X_LAST) ? '0 : cx + 1'b1;
                if (cnt != PRIME) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    bdr_p1 <= (ox == '0) || (ox == X_LAST) || (oy == '0) || (oy == Y_LAST);
                    if (ox == X_LAST) begin
                        ox <= '0;
                        oy <= (oy == Y_LAST) ? '0 : oy + 1'b1;
                    end else begin
                        ox <= ox + 1'b1;
                    end
                end
            end
        end
    end

    // Stage p1 data: line buffer write and window shift on each grey sample
    always_ff @(posedge clk) begin
        if (vld_p0) begin
            lb0[cx] <= grey_p0;
            lb1[cx] <= lb0[cx];
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb1[cx];
            win[1][2] <= lb0[cx];
            win[2][2] <= grey_p0;
        end
    end

    // Sobel gradients and L1 magnitude of the current window
    always_comb begin
        gx  = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
            - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
        gy  = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
            - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
        mag = abs8(gx) + abs8(gy);
    end

    // Stage p2: output register; edge_data holds between pulses, borders forced to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ready <= 1'b0;
            edge_data <= '0;
        end else begin
            out_ready <= vld_p1;
            if (vld_p1) edge_data <= bdr_p1 ? '0 : sat_edge(mag);
        end
    end

endmodule

// File: tb/tb_grey_edge_pipeline.sv
// Scoreboard bench for grey_edge_pipeline with IMG_W=8, IMG_H=6.
module tb_grey_edge_pipeline;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] pixel_in = '0;
    logic        in_ready = 1'b0;
    logic [3:0]  edge_data;
    logic        out_ready;

    logic [11:0] pr_pix = '0;
    logic        pr_vld = 1'b0;
    logic [3:0]  pr_grey;
    logic        pr_vld_o;

    always #5 clk = ~clk;

    grey_edge_pipeline #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .pixel_in  (pixel_in),
        .in_ready  (in_ready),
        .edge_data (edge_data),
        .out_ready (out_ready)
    );

    rgb444_to_grey4 u_probe (
        .clk      (clk),
        .rst      (rst),
        .pixel_in (pr_pix),
        .pix_vld  (pr_vld),
        .grey_p0  (pr_grey),
        .vld_p0   (pr_vld_o)
    );

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   hist[$];
    exp_t sb[$];
    int   act[$];
    int   first_out_cyc = -1;
    int   last_acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int grey_of(input logic [11:0] p);
        int r, g, b;
        r = int'(p[11:8]);
        g = int'(p[7:4]);
        b = int'(p[3:0]);
        return (r + 2 * g + b) / 4;
    endfunction

    function automatic int px(input int k, input int dr, input int dc);
        return hist[k + dr * W + dc];
    endfunction

    // Reference edge value of stream pixel k, computed from the grey history
    function automatic int ref_edge(input int k);
        int x, y, gx, gy, m;
        x = k % W;
        y = (k / W) % H;
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
        gx = (px(k, -1, 1) + 2 * px(k, 0, 1) + px(k, 1, 1))
           - (px(k, -1, -1) + 2 * px(k, 0, -1) + px(k, 1, -1));
        gy = (px(k, 1, -1) + 2 * px(k, 1, 0) + px(k, 1, 1))
           - (px(k, -1, -1) + 2 * px(k, -1, 0) + px(k, -1, 1));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        m = m / 8;
        return (m > 15) ? 15 : m;
    endfunction

    // Hand-derived expectations: 0 uniform, 1 vertical step, 2 horizontal step
    function automatic int dir_exp(input int kind, input int k);
        int x, y;
        x = k % W;
        y = k / W;
        if (kind == 0) return 0;
        if (x == 0 || x == W - 1 || y == 0 || y == H - 1) return 0;
        if (kind == 1) return (x == 3 || x == 4) ? 7 : 0;
        return (y == 2 || y == 3) ? 7 : 0;
    endfunction

    function automatic logic [11:0] gen_pix(input int kind, input int k);
        case (kind)
            0:       return 12'h7A3;
            1:       return ((k % W) >= 4) ? 12'hFFF : 12'h000;
            2:       return ((k / W) >= 3) ? 12'hFFF : 12'h000;
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic send(input logic [11:0] p, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_ready = 1'b1;
        pixel_in = p;
        @(posedge clk);
        #1;
        in_ready = 1'b0;
        last_acc_cyc = cyc;
        hist.push_back(grey_of(p));
        n = hist.size();
        if (n >= W + 2) sb.push_back('{ref_edge(n - 1 - (W + 1)), cyc + 2});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_ready = 1'b1;
        pixel_in = 12'hFFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_ready = 1'b0;
        sb.delete();
        hist.delete();
        act.delete();
        first_out_cyc = -1;
        chk("reset_out_ready", int'(out_ready), 0);
        chk("reset_edge_data", int'(edge_data), 0);
    endtask

    // gapmode: 0 back-to-back, 1 every other cycle, 2 random gaps
    task automatic feed_frame(input int kind, input int gapmode, input int extra);
        int gap;
        for (int k = 0; k < N + extra; k++) begin
            gap = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
            send((k < N) ? gen_pix(kind, k) : ((kind == 3) ? 12'($urandom) : 12'h000), gap);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int kind, input string name);
        chk({name, "_count"}, act.size(), N);
        for (int k = 0; k < N && k < act.size(); k++) begin
            chk(name, act[k], dir_exp(kind, k));
        end
    endtask

    task automatic probe(input logic [11:0] p, input int want);
        @(negedge clk);
        pr_pix = p;
        pr_vld = 1'b1;
        @(posedge clk);
        #1;
        pr_vld = 1'b0;
        chk("grey_probe", int'(pr_grey), want);
        chk("grey_probe_vld", int'(pr_vld_o), 1);
    endtask

    // Monitor: pop the scoreboard on each output pulse and flag missing pulses
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_out: out_ready=1 at cycle %0d, none expected", cyc);
            end else begin
                e = sb.pop_front();
                n_vec++;
                if (int'(edge_data) != e.data || cyc != e.cyc) begin
                    n_err++;
                    $display("FAIL edge_out: got data %0d at cycle %0d, expected %0d at cycle %0d",
                             edge_data, cyc, e.data, e.cyc);
                end
                if (first_out_cyc < 0) first_out_cyc = cyc;
                act.push_back(int'(edge_data));
            end
        end else if (!rst && sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_out: no out_ready by cycle %0d, expected data %0d at cycle %0d",
                     cyc, e.data, e.cyc);
        end
    end

    initial begin
        int acc10;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        probe(12'hF00, 3);
        probe(12'h0F0, 7);
        probe(12'hFFF, 15);
        probe(12'h000, 0);

        feed_frame(0, 0, W + 1);
        check_frame(0, "uniform");

        do_reset();
        feed_frame(1, 2, W + 1);
        check_frame(1, "vstep");

        do_reset();
        feed_frame(2, 2, W + 1);
        check_frame(2, "hstep");

        // Every-other-cycle strobes; first output 2 cycles after the 10th accept
        do_reset();
        acc10 = 0;
        for (int k = 0; k < N + W + 1; k++) begin
            send(12'($urandom), 1);
            if (k == W + 1) acc10 = last_acc_cyc;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("first_out_latency", first_out_cyc, acc10 + 2);
        chk("frame0_pulses", act.size(), N);

        // Reset in the middle of a frame, then a clean vertical step frame
        do_reset();
        for (int k = 0; k < 20; k++) send(12'($urandom), int'($urandom_range(0, 1)));
        do_reset();
        feed_frame(1, 0, W + 1);
        check_frame(1, "vstep_after_reset");

        // Random multi-frame traffic with random gaps
        do_reset();
        feed_frame(3, 2, 0);
        feed_frame(3, 2, W + 1);
        chk("random_pulses", act.size(), 2 * N);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
